// File: rtl/tick_rate_ctrl.sv
// Tick rate controller: run/pause/single-step sequencing of a periodic clock
// enable, with saturating speed levels and a tick-every-cycle fast mode.
module tick_rate_ctrl #(
    parameter int unsigned BASE_CNT = 20_000_000,
    parameter int unsigned LEVELS   = 8,
    parameter int unsigned CNT_W    = $clog2(BASE_CNT) + 1,
    parameter int unsigned LVL_W    = $clog2(LEVELS)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             run_req,
    input  logic             pause_req,
    input  logic             step_req,
    input  logic             speed_up,
    input  logic             speed_down,
    input  logic             fast_mode,
    output logic             tick,
    output logic             running,
    output logic [LVL_W-1:0] level,
    output logic [15:0]      tick_count
);

    typedef enum logic [1:0] {
        PAUSED  = 2'd0,
        RUNNING = 2'd1,
        STEP    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] BASE    = CNT_W'(BASE_CNT);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(LEVELS - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] counter, counter_next;
    logic [LVL_W-1:0] level_next;
    logic             tick_next;

    // Only the highest-priority request is considered; if it does not apply
    // in the current state, the cycle is a no-op.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        tick_next    = 1'b0;
        case (state)
            PAUSED: begin
                if (pause_req) begin
                    state_next = PAUSED;
                end else if (run_req) begin
                    state_next = RUNNING;
                end else if (step_req) begin
                    state_next = STEP;
                    tick_next  = 1'b1;
                end
            end
            RUNNING: begin
                if (pause_req) begin
                    state_next = PAUSED;
                end else begin
                    if (counter == '0) begin
                        counter_next = BASE >> level;
                    end else begin
                        counter_next = counter - 1'b1;
                    end
                    tick_next = fast_mode || (counter == '0);
                end
            end
            STEP: begin
                state_next = PAUSED;
            end
            default: begin
                state_next = PAUSED;
            end
        endcase
    end

    always_comb begin
        level_next = level;
        if (speed_up && !speed_down && (level != LVL_MAX)) begin
            level_next = level + 1'b1;
        end else if (speed_down && !speed_up && (level != '0)) begin
            level_next = level - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= PAUSED;
            counter    <= BASE;
            tick       <= 1'b0;
            running    <= 1'b0;
            level      <= '0;
            tick_count <= '0;
        end else begin
            state      <= state_next;
            counter    <= counter_next;
            tick       <= tick_next;
            running    <= (state_next == RUNNING);
            level      <= level_next;
            tick_count <= tick_count + 16'(tick);
        end
    end

endmodule

// File: tb/tb_tick_rate_ctrl.sv
// Randomised and directed bench for tick_rate_ctrl against a cycle-level
// behavioural model of the run/pause/step/speed rules.
module tb_tick_rate_ctrl;

    localparam int unsigned BASE   = 15;
    localparam int unsigned NLVL   = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        run_req = 1'b0, pause_req = 1'b0, step_req = 1'b0;
    logic        speed_up = 1'b0, speed_down = 1'b0, fast_mode = 1'b0;
    logic        tick, running;
    logic [1:0]  level;
    logic [15:0] tick_count;

    tick_rate_ctrl #(.BASE_CNT(BASE), .LEVELS(NLVL)) dut (
        .clk(clk), .resetn(resetn), .run_req(run_req), .pause_req(pause_req),
        .step_req(step_req), .speed_up(speed_up), .speed_down(speed_down),
        .fast_mode(fast_mode), .tick(tick), .running(running), .level(level),
        .tick_count(tick_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: "is it running", "is a step being issued", cycles left to zero.
    bit m_run, m_step, m_tick;
    int m_rem, m_lvl, m_cnt;

    int ncyc = 0, n_ticks = 0, last_tick_cyc = 0, last_period = 0;

    task automatic model_reset();
        m_run = 0; m_step = 0; m_tick = 0;
        m_rem = BASE; m_lvl = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        bit new_tick = 0;
        if (m_run) begin
            if (pause_req) m_run = 0;
            else begin
                new_tick = fast_mode || (m_rem == 0);
                m_rem = (m_rem == 0) ? (BASE >> m_lvl) : m_rem - 1;
            end
        end else if (m_step) begin
            m_step = 0;
        end else if (!pause_req) begin
            if (run_req) m_run = 1;
            else if (step_req) begin
                m_step = 1;
                new_tick = 1;
            end
        end
        if (speed_up && !speed_down && m_lvl < NLVL - 1) m_lvl++;
        else if (speed_down && !speed_up && m_lvl > 0) m_lvl--;
        m_cnt = (m_cnt + int'(m_tick)) % 65536;
        m_tick = new_tick;
    endtask

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, ncyc);
        end
    endtask

    task automatic compare();
        vectors++;
        if (tick !== m_tick || running !== m_run || level !== 2'(m_lvl) ||
            tick_count !== 16'(m_cnt)) begin
            miscompares++;
            $display("FAIL model cyc%0d: tick=%b/%b running=%b/%b level=%0d/%0d count=%0d/%0d",
                     ncyc, tick, m_tick, running, m_run, level, m_lvl, tick_count, m_cnt);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        ncyc++;
        #1;
        compare();
        if (tick === 1'b1) begin
            n_ticks++;
            last_period = ncyc - last_tick_cyc;
            last_tick_cyc = ncyc;
        end
        run_req = 0; pause_req = 0; step_req = 0; speed_up = 0; speed_down = 0;
    endtask

    task automatic wait_tick(input int bound);
        for (int i = 0; i < bound; i++) begin
            cycle();
            if (tick === 1'b1) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL wait_tick: no tick within %0d cycles, required one", bound);
    endtask

    initial begin
        int t0, nr;
        model_reset();
        repeat (3) @(posedge clk);
        #3 resetn = 1'b1;

        // Idle after reset
        repeat (40) cycle();
        check("idle_ticks", n_ticks, 0);
        check("idle_running", int'(running), 0);
        check("idle_count", int'(tick_count), 0);

        // Level-0 cadence
        run_req = 1; cycle();
        check("run_running", int'(running), 1);
        repeat (5) wait_tick(40);
        check("l0_period", last_period, 16);
        cycle();
        check("l0_count5", int'(tick_count), 5);

        // Speed change mid-period and saturation
        wait_tick(40);
        repeat (4) cycle();
        speed_up = 1; cycle();
        wait_tick(40);
        check("inflight_period", last_period, 16);
        wait_tick(40);
        check("l1_period", last_period, 8);
        repeat (3) begin speed_up = 1; cycle(); end
        check("level_sat", int'(level), 3);
        repeat (3) wait_tick(40);
        check("l3_period", last_period, 2);
        repeat (4) begin speed_down = 1; cycle(); end
        check("level_floor", int'(level), 0);
        speed_up = 1; speed_down = 1; cycle();
        check("updown_at0", int'(level), 0);
        speed_up = 1; cycle();
        speed_up = 1; speed_down = 1; cycle();
        check("updown_at1", int'(level), 1);
        speed_down = 1; cycle();

        // Pause / step / resume
        repeat (2) wait_tick(40);
        repeat (4) cycle();
        pause_req = 1; cycle();
        t0 = n_ticks;
        repeat (20) cycle();
        check("paused_ticks", n_ticks - t0, 0);
        t0 = int'(tick_count);
        step_req = 1; cycle();
        check("step_tick", int'(tick), 1);
        cycle();
        check("step_tick_len", int'(tick), 0);
        check("step_count", int'(tick_count), (t0 + 1) % 65536);
        run_req = 1; cycle();
        nr = ncyc;
        wait_tick(40);
        check("resume_gap", ncyc - nr, 12);
        step_req = 1; cycle();
        repeat (3) cycle();
        pause_req = 1; run_req = 1; cycle();
        check("pause_over_run", int'(running), 0);

        // Fast mode
        run_req = 1; cycle();
        wait_tick(40);
        fast_mode = 1;
        t0 = n_ticks;
        repeat (10) cycle();
        check("fast_ticks", n_ticks - t0, 10);
        fast_mode = 0;
        pause_req = 1; cycle();
        fast_mode = 1;
        t0 = n_ticks;
        repeat (20) cycle();
        check("fast_paused", n_ticks - t0, 0);
        fast_mode = 0;

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            run_req    = ($urandom_range(0, 15) == 0);
            pause_req  = ($urandom_range(0, 19) == 0);
            step_req   = ($urandom_range(0, 9) == 0);
            speed_up   = ($urandom_range(0, 24) == 0);
            speed_down = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 39) == 0) fast_mode = ~fast_mode;
            cycle();
        end

        // Wrap of tick_count
        fast_mode = 1;
        run_req = 1; cycle();
        for (int i = 0; i < 70000 && tick_count !== 16'hFFFF; i++) cycle();
        check("reach_ffff", int'(tick_count), 65535);
        check("tick_at_ffff", int'(tick), 1);
        cycle();
        check("wrap_zero", int'(tick_count), 0);
        repeat (7) cycle();

        // Asynchronous reset mid-count
        #2 resetn = 1'b0;
        #1;
        check("arst_tick", int'(tick), 0);
        check("arst_running", int'(running), 0);
        check("arst_level", int'(level), 0);
        check("arst_count", int'(tick_count), 0);
        model_reset();
        fast_mode = 0;
        #2 resetn = 1'b1;
        repeat (20) cycle();
        check("post_reset_ticks", int'(tick_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
